muldiv_unit: RTL and testbench

- Execute-stage HI/LO unit for the MIPS pipeline, directly downstream of the control decoder.
- Consumes the decoder's multiply, divide, unsigned, mthi and mtlo controls, plus the forwarded rs/rt operands.
- Owns the architectural HI/LO registers.
- Runs signed/unsigned 32x32 multiply (fixed latency) and signed/unsigned 32/32 divide (iterative, radix-2 restoring).
- Exports busy so the hazard unit can stall mfhi/mflo and further mult/div.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_div_radix2.sv | 67 ++++++
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM encoding,
// datapath widths, divide-by-zero policy and a two's-complement helper.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int DXLEN = 64;

  // A zero divisor skips the iteration phase entirely and leaves HI/LO as they were.
  localparam bit DIV0_SKIP_ITER = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

endpackage

// File: rtl/muldiv_div_radix2.sv
// Iterative radix-2 restoring divider core on unsigned magnitudes.
// One quotient bit per cycle; ITERS cycles after i_start the quotient and
// remainder are valid and stay stable until the next start.
module div_radix2
  import muldiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_last,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int CW = $clog2(ITERS + 1);

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;

  // The shifted partial remainder needs one extra bit: it can reach 2*divisor-1.
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  // When the trial subtract succeeds the true difference is below the divisor,
  // so the low XLEN bits of the modular subtraction are exact.
  assign w_diff  = w_shift[XLEN-1:0] - r_dvs;

  // Load operands on start, then shift/trial-subtract once per cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(ITERS);
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (r_cnt != '0) begin
      r_rem <= w_ge ? w_diff : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy      = (r_cnt != '0);
  assign o_last      = (r_cnt == CW'(1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage HI/LO unit: owns HI/LO, runs fixed-latency 32x32 multiply and
// iterative 32/32 divide, and reports busy/done to the hazard logic.
// Optional build macro MULDIV_DIV0_FLAG_EN adds div_zero / div_zero_sticky.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_start,
  input  logic            div_start,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  input  logic            cancel,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic            div_zero,
  output logic            div_zero_sticky
`endif
);

  state_e r_state, w_state_next;

  logic [XLEN-1:0] r_hi, r_lo;
  logic            r_done;
  logic [XLEN-1:0] r_mul_a, r_mul_b;
  logic            r_mul_uns;
  logic [3:0]      r_mul_cnt;
  logic            r_q_neg, r_r_neg, r_div0;

  logic w_mul_go, w_div_go, w_div0_go, w_mul_fin, w_fix_fin, w_mt_en;

  // Divide operand magnitudes and multiply product.
  logic [XLEN-1:0]  w_abs_a, w_abs_b;
  logic [DXLEN-1:0] w_mul_a, w_mul_b, w_prod;
  logic [XLEN-1:0]  w_quo, w_rem, w_q_fix, w_r_fix;
  logic             w_div_busy, w_div_last;

  assign w_abs_a = (!is_unsigned && op_a[XLEN-1]) ? negate(op_a) : op_a;
  assign w_abs_b = (!is_unsigned && op_b[XLEN-1]) ? negate(op_b) : op_b;

  // Sign-extending (or zero-extending) to 64 bits gives the same low 64 product
  // bits as the 33-bit signed formulation.
  assign w_mul_a = {{XLEN{~r_mul_uns & r_mul_a[XLEN-1]}}, r_mul_a};
  assign w_mul_b = {{XLEN{~r_mul_uns & r_mul_b[XLEN-1]}}, r_mul_b};
  assign w_prod  = w_mul_a * w_mul_b;

  assign w_q_fix = r_q_neg ? negate(w_quo) : w_quo;
  assign w_r_fix = r_r_neg ? negate(w_rem) : w_rem;

  div_radix2 #(
    .ITERS(DIV_ITERS)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_go),
    .i_abort    (cancel),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_busy     (w_div_busy),
    .o_last     (w_div_last),
    .o_quotient (w_quo),
    .o_remainder(w_rem)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and per-cycle control strobes.
  // NOTE: every output gets a default first, so no path through the case can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_mul_go     = 1'b0;
    w_div_go     = 1'b0;
    w_div0_go    = 1'b0;
    w_mul_fin    = 1'b0;
    w_fix_fin    = 1'b0;
    w_mt_en      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!cancel && mul_start) begin
          w_mul_go     = 1'b1;
          w_state_next = ST_MUL;
        end else if (!cancel && div_start) begin
          if (DIV0_SKIP_ITER && op_b == '0) begin
            w_div0_go    = 1'b1;
            w_state_next = ST_FIX;
          end else begin
            w_div_go     = 1'b1;
            w_state_next = ST_DIV;
          end
        end else begin
          w_mt_en = 1'b1;
        end
      end
      ST_MUL: begin
        if (cancel) begin
          w_state_next = ST_IDLE;
        end else if (r_mul_cnt == 4'd1) begin
          w_mul_fin    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (cancel)                        w_state_next = ST_IDLE;
        else if (w_div_last || !w_div_busy) w_state_next = ST_FIX;
      end
      ST_FIX: begin
        w_state_next = ST_IDLE;
        w_fix_fin    = !cancel;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // HI/LO, operand latches, multiply countdown and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_uns <= 1'b0;
      r_mul_cnt <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      r_done <= w_mul_fin | w_fix_fin;

      if (w_mul_go) begin
        r_mul_a   <= op_a;
        r_mul_b   <= op_b;
        r_mul_uns <= is_unsigned;
        r_mul_cnt <= 4'(MUL_CYCLES);
      end else if (r_state == ST_MUL) begin
        r_mul_cnt <= r_mul_cnt - 4'd1;
      end

      if (w_div_go || w_div0_go) begin
        r_q_neg <= ~is_unsigned & (op_a[XLEN-1] ^ op_b[XLEN-1]);
        r_r_neg <= ~is_unsigned & op_a[XLEN-1];
        r_div0  <= w_div0_go;
      end

      if (w_mul_fin) begin
        r_hi <= w_prod[DXLEN-1:XLEN];
        r_lo <= w_prod[XLEN-1:0];
      end else if (w_fix_fin && !r_div0) begin
        r_hi <= w_r_fix;
        r_lo <= w_q_fix;
      end else if (w_mt_en) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

`ifdef MULDIV_DIV0_FLAG_EN
  logic r_div_zero, r_div_zero_sticky;

  // Divide-by-zero pulse alongside done, plus a flag held until a good divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_zero        <= 1'b0;
      r_div_zero_sticky <= 1'b0;
    end else begin
      r_div_zero <= w_fix_fin & r_div0;
      if (w_fix_fin) r_div_zero_sticky <= r_div0;
    end
  end

  assign div_zero        = r_div_zero;
  assign div_zero_sticky = r_div_zero_sticky;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases followed by
// random multiply/divide traffic against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int MUL_N = 4;

  logic        clk = 1'b0;
  logic        rst, mul_start, div_start, is_unsigned, mthi, mtlo, cancel;
  logic [31:0] op_a, op_b, wdata, hi, lo;
  logic        busy, done;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div_zero, div_zero_sticky;
  logic        m_sticky = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_unit #(
    .MUL_CYCLES(MUL_N),
    .DIV_ITERS (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mul_start  (mul_start),
    .div_start  (div_start),
    .is_unsigned(is_unsigned),
    .op_a       (op_a),
    .op_b       (op_b),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .cancel     (cancel),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    .div_zero       (div_zero),
    .div_zero_sticky(div_zero_sticky)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; C-style truncating division matches MIPS.
  task automatic model(input bit is_div, input bit uns, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output int ecyc);
    longint x, y, q, r;
    logic [63:0] p;
    x = uns ? longint'({32'b0, a}) : longint'($signed(a));
    y = uns ? longint'({32'b0, b}) : longint'($signed(b));
    if (!is_div) begin
      p = x * y;
      ehi = p[63:32]; elo = p[31:0]; ecyc = MUL_N;
    end else if (b == 0) begin
      ehi = m_hi; elo = m_lo; ecyc = 1;
    end else begin
      q = x / y; r = x % y;
      p = q; elo = p[31:0];
      p = r; ehi = p[31:0];
      ecyc = 33;
    end
  endtask

  // Issue one operation in the current cycle and follow it to completion.
  // mt_same: mthi in the start cycle. disturb: mt writes and new starts while busy.
  task automatic run_op(input string tag, input bit is_div, input bit uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit mt_same, input bit disturb);
    logic [31:0] ehi, elo;
    int ecyc, n;
    bit early;
    model(is_div, uns, a, b, ehi, elo, ecyc);
    mul_start = !is_div; div_start = is_div; is_unsigned = uns;
    op_a = a; op_b = b; mthi = mt_same; wdata = 32'h0000DEAD;
    @(negedge clk);
    mul_start = 0; div_start = 0; mthi = 0;
    n = 0; early = 0;
    while (busy === 1'b1 && n < 100) begin
      if (done !== 1'b0) early = 1;
      if (disturb && n == 0) begin
        mthi = 1; mtlo = 1; wdata = 32'hAAAA5555; mul_start = 1; div_start = 1;
      end else if (disturb && n == 1) begin
        mthi = 0; mtlo = 0; mul_start = 0; div_start = 0;
        check({tag, " hi mid-op"}, hi, m_hi);
      end
      n++;
      @(negedge clk);
    end
    mthi = 0; mtlo = 0; mul_start = 0; div_start = 0;
    check({tag, " busy cycles"}, 32'(n), 32'(ecyc));
    check({tag, " early done"}, {31'b0, early}, 32'd0);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
`ifdef MULDIV_DIV0_FLAG_EN
    check({tag, " div_zero"}, {31'b0, div_zero}, {31'b0, is_div && b == 0});
    if (is_div) m_sticky = (b == 0);
    check({tag, " sticky"}, {31'b0, div_zero_sticky}, {31'b0, m_sticky});
`endif
    m_hi = ehi; m_lo = elo;
    @(negedge clk);
    check({tag, " done pulse width"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst = 1; mul_start = 0; div_start = 0; is_unsigned = 0; mthi = 0; mtlo = 0;
    cancel = 0; op_a = 0; op_b = 0; wdata = 0;
    repeat (2) @(negedge clk);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    rst = 0;
    @(negedge clk);

    run_op("mult -3x5", 0, 0, 32'hFFFFFFFD, 32'd5, 0, 0);
    check("mult -3x5 const hi", hi, 32'hFFFFFFFF);
    check("mult -3x5 const lo", lo, 32'hFFFFFFF1);
    run_op("multu max", 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    check("multu max const hi", hi, 32'hFFFFFFFE);
    run_op("div -7/2", 1, 0, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div -7/2 const lo", lo, 32'hFFFFFFFD);
    run_op("divu 7/2", 1, 1, 32'd7, 32'd2, 0, 0);
    run_op("div min/-1", 1, 0, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    check("div min/-1 const lo", lo, 32'h80000000);

    // mthi then mtlo while idle; neither produces done.
    mthi = 1; wdata = 32'h00001234;
    @(negedge clk);
    mthi = 0; mtlo = 1; wdata = 32'h00005678;
    @(negedge clk);
    mtlo = 0;
    check("mthi", hi, 32'h00001234);
    check("mtlo", lo, 32'h00005678);
    check("mt no done", {31'b0, done}, 32'd0);
    m_hi = 32'h00001234; m_lo = 32'h00005678;

    // Divide by zero, with a same-cycle mthi that the start must drop.
    run_op("div 9/0", 1, 0, 32'd9, 32'd0, 1, 0);
    check("div 9/0 const hi", hi, 32'h00001234);
    run_op("div0 busy mt", 1, 1, 32'd5, 32'd0, 0, 1);
    run_op("div busy mt/start", 1, 0, 32'd100, 32'd7, 0, 1);

    // Cancel in T+10 of a divide; a multiply follows straight away.
    div_start = 1; is_unsigned = 0; op_a = 32'd100; op_b = 32'd3;
    @(negedge clk);
    div_start = 0;
    repeat (9) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("cancel busy", {31'b0, busy}, 32'd0);
    check("cancel done", {31'b0, done}, 32'd0);
    check("cancel hi", hi, m_hi);
    check("cancel lo", lo, m_lo);
    run_op("mult after cancel", 0, 0, 32'd7, 32'hFFFFFFFE, 0, 0);

    // Cancel in the same cycle as a start suppresses it.
    mul_start = 1; cancel = 1; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    mul_start = 0; cancel = 0;
    check("cancel+start busy", {31'b0, busy}, 32'd0);
    repeat (MUL_N + 1) @(negedge clk);
    check("cancel+start lo", lo, m_lo);

    // Reset in T+5 of a divide.
    div_start = 1; op_a = 32'd50; op_b = 32'd3;
    @(negedge clk);
    div_start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid-op reset hi", hi, 32'd0);
    check("mid-op reset lo", lo, 32'd0);
    check("mid-op reset busy", {31'b0, busy}, 32'd0);
    m_hi = 0; m_lo = 0;
`ifdef MULDIV_DIV0_FLAG_EN
    m_sticky = 0;
`endif
    run_op("mult after reset", 0, 1, 32'h00010000, 32'h00010000, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      bit rdiv, runs;
      rdiv = 1'($urandom_range(0, 1));
      runs = 1'($urandom_range(0, 1));
      ra   = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rdiv, runs, ra, rb, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
